// File: rtl/amer_put_pkg.sv
// Shared definitions for the amer_put host control slice: address map,
// controller states and the default cycle budgets for an n=4000 run.
package amer_put_pkg;

   localparam int DEF_S1_CYCLES  = 16384;
   localparam int DEF_RUN_CYCLES = 2100000;
   localparam int DEF_CNT_W      = 24;

   localparam int ADDR_W  = 4;
   localparam int DATA_W  = 32;
   localparam int PARAM_W = 64;

   localparam logic [ADDR_W-1:0] ADDR_P_UP_LO    = 4'd0;
   localparam logic [ADDR_W-1:0] ADDR_P_UP_HI    = 4'd1;
   localparam logic [ADDR_W-1:0] ADDR_P_DOWN_LO  = 4'd2;
   localparam logic [ADDR_W-1:0] ADDR_P_DOWN_HI  = 4'd3;
   localparam logic [ADDR_W-1:0] ADDR_LL_UP_LO   = 4'd4;
   localparam logic [ADDR_W-1:0] ADDR_LL_UP_HI   = 4'd5;
   localparam logic [ADDR_W-1:0] ADDR_LL_DOWN_LO = 4'd6;
   localparam logic [ADDR_W-1:0] ADDR_LL_DOWN_HI = 4'd7;
   localparam logic [ADDR_W-1:0] ADDR_K_S_LO     = 4'd8;
   localparam logic [ADDR_W-1:0] ADDR_K_S_HI     = 4'd9;
   localparam logic [ADDR_W-1:0] ADDR_RESULT_LO  = 4'd10;
   localparam logic [ADDR_W-1:0] ADDR_RESULT_HI  = 4'd11;
   localparam logic [ADDR_W-1:0] ADDR_STATUS     = 4'd12;

   typedef enum logic [2:0] {
      IDLE,
      PULSE1,
      WAIT1,
      PULSE2,
      RUN,
      CAPTURE
   } state_t;

   // Odd word addresses select the upper half of a 64-bit register.
   function automatic logic [DATA_W-1:0] pick_half(input logic [PARAM_W-1:0] v,
                                                   input logic hi);
      return hi ? v[PARAM_W-1:DATA_W] : v[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/amer_put_host_ctrl_if.sv
// Host word bus: one 32-bit write port and one registered 32-bit read port.
interface amer_put_host_ctrl_if;
   import amer_put_pkg::*;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;

   modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
   modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);

endinterface

// File: rtl/amer_put_param_regs.sv
// Host-visible register file: five 64-bit option parameters assembled from
// 32-bit halves, locked while a run is in flight, plus the readback mux.
module amer_put_param_regs
   import amer_put_pkg::*;
(
   input  logic                clk,
   input  logic                nrst,
   amer_put_host_ctrl_if.slave host,
   input  logic                busy,
   input  logic                done,
   input  logic [PARAM_W-1:0]  result,
   output logic [PARAM_W-1:0]  p_up,
   output logic [PARAM_W-1:0]  p_down,
   output logic [PARAM_W-1:0]  log_lambda_up,
   output logic [PARAM_W-1:0]  log_lambda_down,
   output logic [PARAM_W-1:0]  K_over_S
);

   logic [DATA_W-1:0] rd_next;

   // Parameters must not move under the core, so the whole write path is gated by busy.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         p_up            <= '0;
         p_down          <= '0;
         log_lambda_up   <= '0;
         log_lambda_down <= '0;
         K_over_S        <= '0;
      end else if (host.wr_en && !busy) begin
         case (host.wr_addr)
            ADDR_P_UP_LO:    p_up[DATA_W-1:0]                     <= host.wr_data;
            ADDR_P_UP_HI:    p_up[PARAM_W-1:DATA_W]               <= host.wr_data;
            ADDR_P_DOWN_LO:  p_down[DATA_W-1:0]                   <= host.wr_data;
            ADDR_P_DOWN_HI:  p_down[PARAM_W-1:DATA_W]             <= host.wr_data;
            ADDR_LL_UP_LO:   log_lambda_up[DATA_W-1:0]            <= host.wr_data;
            ADDR_LL_UP_HI:   log_lambda_up[PARAM_W-1:DATA_W]      <= host.wr_data;
            ADDR_LL_DOWN_LO: log_lambda_down[DATA_W-1:0]          <= host.wr_data;
            ADDR_LL_DOWN_HI: log_lambda_down[PARAM_W-1:DATA_W]    <= host.wr_data;
            ADDR_K_S_LO:     K_over_S[DATA_W-1:0]                 <= host.wr_data;
            ADDR_K_S_HI:     K_over_S[PARAM_W-1:DATA_W]           <= host.wr_data;
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_next = '0;
      case (host.rd_addr)
         ADDR_P_UP_LO, ADDR_P_UP_HI:       rd_next = pick_half(p_up, host.rd_addr[0]);
         ADDR_P_DOWN_LO, ADDR_P_DOWN_HI:   rd_next = pick_half(p_down, host.rd_addr[0]);
         ADDR_LL_UP_LO, ADDR_LL_UP_HI:     rd_next = pick_half(log_lambda_up, host.rd_addr[0]);
         ADDR_LL_DOWN_LO, ADDR_LL_DOWN_HI: rd_next = pick_half(log_lambda_down, host.rd_addr[0]);
         ADDR_K_S_LO, ADDR_K_S_HI:         rd_next = pick_half(K_over_S, host.rd_addr[0]);
         ADDR_RESULT_LO, ADDR_RESULT_HI:   rd_next = pick_half(result, host.rd_addr[0]);
         ADDR_STATUS:                      rd_next = {30'b0, done, busy};
         default:                          rd_next = '0;
      endcase
   end

   // Reading pre-edge register values means a same-cycle write is not visible yet.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         host.rd_data <= '0;
      end else begin
         host.rd_data <= rd_next;
      end
   end

endmodule

// File: rtl/amer_put_host_ctrl.sv
// Host control stage for the amer_put core: sequences start_s1/start_s2,
// waits fixed cycle budgets and captures the core result for readback.
module amer_put_host_ctrl
   import amer_put_pkg::*;
#(
   parameter int S1_CYCLES  = DEF_S1_CYCLES,
   parameter int RUN_CYCLES = DEF_RUN_CYCLES,
   parameter int CNT_W      = DEF_CNT_W
)(
   input  logic                clk,
   input  logic                nrst,
   amer_put_host_ctrl_if.slave host,
   input  logic                go,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   output logic                start_s1,
   output logic                start_s2,
   output logic [PARAM_W-1:0]  p_up,
   output logic [PARAM_W-1:0]  p_down,
   output logic [PARAM_W-1:0]  log_lambda_up,
   output logic [PARAM_W-1:0]  log_lambda_down,
   output logic [PARAM_W-1:0]  K_over_S,
   input  logic [PARAM_W-1:0]  result_in
);

   localparam logic [CNT_W-1:0] S1_LAST  = CNT_W'(S1_CYCLES - 1);
   localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(RUN_CYCLES - 1);

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   counter;
   logic [PARAM_W-1:0] result_q;

   amer_put_param_regs u_regs (
      .clk             (clk),
      .nrst            (nrst),
      .host            (host),
      .busy            (busy),
      .done            (done),
      .result          (result_q),
      .p_up            (p_up),
      .p_down          (p_down),
      .log_lambda_up   (log_lambda_up),
      .log_lambda_down (log_lambda_down),
      .K_over_S        (K_over_S)
   );

   // Abort overrides every transition, including a go arriving in IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (go) state_next = PULSE1;
         PULSE1:  state_next = WAIT1;
         WAIT1:   if (counter == S1_LAST) state_next = PULSE2;
         PULSE2:  state_next = RUN;
         RUN:     if (counter == RUN_LAST) state_next = CAPTURE;
         CAPTURE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (abort) state_next = IDLE;
   end

   // Pulses and busy are decoded from the next state so they appear registered
   // in the cycle the FSM occupies PULSE1/PULSE2, and vanish on abort.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state    <= IDLE;
         counter  <= '0;
         result_q <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         start_s1 <= 1'b0;
         start_s2 <= 1'b0;
      end else begin
         state    <= state_next;
         start_s1 <= (state_next == PULSE1);
         start_s2 <= (state_next == PULSE2);
         busy     <= (state_next != IDLE);

         case (state)
            PULSE1, PULSE2: counter <= '0;
            WAIT1, RUN:     counter <= counter + 1'b1;
            default:        counter <= counter;
         endcase

         if (state == IDLE && state_next == PULSE1) begin
            done <= 1'b0;
         end
         if (state == CAPTURE && !abort) begin
            result_q <= result_in;
            done     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_amer_put_host_ctrl.sv
// Self-checking bench: directed timeline checks with literal expectations plus
// randomized traffic compared every cycle against a timeline-level model.
module tb_amer_put_host_ctrl;

   localparam int S1  = 4;
   localparam int RUN = 10;

   logic        clk;
   logic        nrst;
   logic        go;
   logic        abort;
   logic        busy;
   logic        done;
   logic        start_s1;
   logic        start_s2;
   logic [63:0] p_up;
   logic [63:0] p_down;
   logic [63:0] log_lambda_up;
   logic [63:0] log_lambda_down;
   logic [63:0] K_over_S;
   logic [63:0] result_in;

   int tests_run;
   int tests_failed;

   amer_put_host_ctrl_if host ();

   amer_put_host_ctrl #(
      .S1_CYCLES  (S1),
      .RUN_CYCLES (RUN),
      .CNT_W      (24)
   ) dut (
      .clk             (clk),
      .nrst            (nrst),
      .host            (host),
      .go              (go),
      .abort           (abort),
      .busy            (busy),
      .done            (done),
      .start_s1        (start_s1),
      .start_s2        (start_s2),
      .p_up            (p_up),
      .p_down          (p_down),
      .log_lambda_up   (log_lambda_up),
      .log_lambda_down (log_lambda_down),
      .K_over_S        (K_over_S),
      .result_in       (result_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Model state: what the outputs must be after each edge, from the timeline rules.
   logic [63:0] m_param [5];
   logic [63:0] m_result;
   logic        m_busy;
   logic        m_done;
   logic        m_active;
   logic        m_s1;
   logic        m_s2;
   logic [31:0] m_rd;
   int          m_go_cyc;
   int          cyc;

   function automatic logic [31:0] model_read(input logic [3:0] a);
      logic [63:0] v;
      if (a < 4'd10) begin
         v = m_param[int'(a) / 2];
         return a[0] ? v[63:32] : v[31:0];
      end
      if (a == 4'd10) return m_result[31:0];
      if (a == 4'd11) return m_result[63:32];
      if (a == 4'd12) return {30'b0, m_done, m_busy};
      return 32'h0;
   endfunction

   initial begin : model_and_compare
      logic        seen_reset;
      logic        n_s, we_s, go_s, ab_s;
      logic [3:0]  wa_s, ra_s;
      logic [31:0] wd_s;
      logic [63:0] res_s;
      int          idx;
      seen_reset = 1'b0;
      cyc = 0;
      forever begin
         @(posedge clk);
         n_s = nrst; we_s = host.wr_en; wa_s = host.wr_addr; wd_s = host.wr_data;
         ra_s = host.rd_addr; go_s = go; ab_s = abort; res_s = result_in;
         #1;
         if (!n_s) begin
            seen_reset = 1'b1;
            for (int i = 0; i < 5; i++) m_param[i] = '0;
            m_result = '0; m_busy = 0; m_done = 0; m_active = 0;
            m_s1 = 0; m_s2 = 0; m_rd = '0; m_go_cyc = 0;
         end else if (seen_reset) begin
            m_rd = model_read(ra_s);
            if (we_s && !m_busy && wa_s < 4'd10) begin
               idx = int'(wa_s) / 2;
               if (wa_s[0]) m_param[idx][63:32] = wd_s;
               else         m_param[idx][31:0]  = wd_s;
            end
            if (!m_active) begin
               if (go_s && !ab_s) begin
                  m_active = 1; m_go_cyc = cyc; m_done = 0;
               end
            end else if (ab_s) begin
               m_active = 0;
            end else if (cyc == m_go_cyc + S1 + RUN + 3) begin
               m_active = 0; m_done = 1; m_result = res_s;
            end
            m_busy = m_active;
            m_s1 = m_active && (cyc + 1 == m_go_cyc + 1);
            m_s2 = m_active && (cyc + 1 == m_go_cyc + S1 + 2);
         end
         cyc++;
         if (seen_reset) begin
            check_output("m_start_s1", 64'(start_s1), 64'(m_s1));
            check_output("m_start_s2", 64'(start_s2), 64'(m_s2));
            check_output("m_busy", 64'(busy), 64'(m_busy));
            check_output("m_done", 64'(done), 64'(m_done));
            check_output("m_rd_data", 64'(host.rd_data), 64'(m_rd));
            check_output("m_p_up", p_up, m_param[0]);
            check_output("m_p_down", p_down, m_param[1]);
            check_output("m_ll_up", log_lambda_up, m_param[2]);
            check_output("m_ll_down", log_lambda_down, m_param[3]);
            check_output("m_k_over_s", K_over_S, m_param[4]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic write_word(input logic [3:0] a, input logic [31:0] d);
      host.wr_en = 1'b1; host.wr_addr = a; host.wr_data = d;
      tick();
      host.wr_en = 1'b0;
   endtask

   task automatic read_check(input string nm, input logic [3:0] a, input logic [31:0] exp);
      host.rd_addr = a;
      tick();
      check_output(nm, 64'(host.rd_data), 64'(exp));
   endtask

   // go is raised in cycle 0; k counts cycles after that edge.
   task automatic run_sequence(input int abort_at, input int reset_at, input int write_at);
      int stop_at;
      stop_at = (abort_at > 0) ? abort_at : ((reset_at > 0) ? reset_at : 1000);
      go = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         go = 1'b0; abort = 1'b0; nrst = 1'b1; host.wr_en = 1'b0;
         check_output("seq_start_s1", 64'(start_s1), 64'(k == 1 && k <= stop_at));
         check_output("seq_start_s2", 64'(start_s2), 64'(k == 6 && k <= stop_at));
         check_output("seq_busy", 64'(busy), 64'(k >= 1 && k <= 17 && k <= stop_at));
         check_output("seq_done", 64'(done), 64'(stop_at == 1000 && k >= 18));
         if (k == abort_at) abort = 1'b1;
         if (k == reset_at) nrst = 1'b0;
         if (k == write_at) begin
            host.wr_en = 1'b1; host.wr_addr = 4'd2; host.wr_data = 32'hDEAD_BEEF; go = 1'b1;
         end
      end
   endtask

   task automatic apply_stimulus();
      nrst          = ($urandom_range(0, 299) != 0);
      host.wr_en    = 1'($urandom_range(0, 1));
      host.wr_addr  = 4'($urandom_range(0, 15));
      host.wr_data  = $urandom;
      host.rd_addr  = 4'($urandom_range(0, 15));
      go            = ($urandom_range(0, 19) == 0);
      abort         = ($urandom_range(0, 59) == 0);
      result_in     = {$urandom, $urandom};
   endtask

   initial begin : stimulus
      tests_run = 0;
      tests_failed = 0;
      nrst = 1'b0; go = 1'b0; abort = 1'b0; result_in = '0;
      host.wr_en = 1'b0; host.wr_addr = '0; host.wr_data = '0; host.rd_addr = '0;
      tick();
      tick();
      nrst = 1'b1;
      for (int a = 0; a <= 12; a++) read_check("reset_read", 4'(a), 32'h0);
      check_output("reset_busy", 64'(busy), 64'h0);
      check_output("reset_done", 64'(done), 64'h0);

      write_word(4'd1, 32'h3FE0_0000);
      write_word(4'd0, 32'h0000_0001);
      check_output("p_up_value", p_up, 64'h3FE00000_00000001);
      read_check("p_up_lo", 4'd0, 32'h0000_0001);
      read_check("p_up_hi", 4'd1, 32'h3FE0_0000);

      result_in = 64'h4004_0000_0000_0000;
      run_sequence(0, 0, 0);
      read_check("result_lo", 4'd10, 32'h0000_0000);
      read_check("result_hi", 4'd11, 32'h4004_0000);
      read_check("status_done", 4'd12, 32'h0000_0002);

      run_sequence(0, 0, 3);
      check_output("p_down_locked", p_down, 64'h0);

      result_in = 64'h1111_2222_3333_4444;
      run_sequence(9, 0, 0);
      read_check("abort_result_hi", 4'd11, 32'h4004_0000);
      read_check("abort_status", 4'd12, 32'h0000_0000);
      run_sequence(0, 0, 0);
      read_check("rerun_result_lo", 4'd10, 32'h3333_4444);

      run_sequence(0, 3, 0);
      check_output("reset_p_up", p_up, 64'h0);
      read_check("reset_result_hi", 4'd11, 32'h0);
      run_sequence(0, 0, 0);

      for (int i = 0; i < 3000; i++) begin
         apply_stimulus();
         tick();
      end
      nrst = 1'b1; go = 1'b0; abort = 1'b0; host.wr_en = 1'b0;
      tick();
      tick();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/amer_put_host_ctrl.md
Name: amer_put_host_ctrl

Overview:
- Host-facing control and parameter stage upstream of the amer_put core, on the fast clock domain.
- Accepts 32-bit host writes and assembles them into the five 64-bit option parameters (p_up, p_down, log_lambda_up, log_lambda_down, K_over_S).
- Sequences the core's start_s1/start_s2 pulses, waits a fixed cycle budget, then captures the 64-bit core result and presents it for host readback.

Parameters:
- S1_CYCLES, 16384, cycles from start_s1 pulse to start_s2 pulse (covers vex/membank init).
- RUN_CYCLES, 2100000, cycles from start_s2 pulse to result capture (covers n=4000 backward induction plus pipeline drain).
- CNT_W, 24, width of the wait counter; must satisfy 2^CNT_W > max(S1_CYCLES, RUN_CYCLES).

Ports:
- clk  in  1  clock (same as core fast clock)
- nrst  in  1  synchronous reset, active low
- wr_en  in  1  host write strobe, one word per cycle
- wr_addr  in  4  host word address
- wr_data  in  32  host write data
- rd_addr  in  4  host read word address
- rd_data  out  32  registered read data, 1-cycle latency
- go  in  1  start request, single-cycle pulse
- abort  in  1  cancel run, return to IDLE
- busy  out  1  high from go acceptance until DONE or abort
- done  out  1  sticky result-valid flag, cleared by next accepted go or by reset
- start_s1  out  1  one-cycle pulse to core
- start_s2  out  1  one-cycle pulse to core
- p_up, p_down, log_lambda_up, log_lambda_down, K_over_S  out  64 each  parameter registers to core
- result_in  in  64  core result (c0 memory output)

Behaviour:
- Reset: clk and nrst are a single clock with synchronous, active-low reset.
  - All parameter registers, result register, rd_data and counter are 0.
  - busy=0, done=0, start_s1=0, start_s2=0; state=IDLE.
  - Reset mid-run behaves identically; no pulse is emitted in the reset cycle.
- Address map (word): 0/1 p_up lo/hi; 2/3 p_down lo/hi; 4/5 log_lambda_up lo/hi; 6/7 log_lambda_down lo/hi; 8/9 K_over_S lo/hi; 10/11 result lo/hi (read-only); 12 status {30'b0, done, busy} (read-only).
  - Addresses 13-15 read 0.
  - Writes to 10-15 are ignored.
- Writes:
  - A write updates only the addressed 32-bit half on the next edge.
  - Writes are ignored while busy=1, so parameters are stable for the whole run.
  - Reads are allowed at any time.
  - A write and a read to the same address in the same cycle: rd_data returns the old value.
- FSM states and transitions:
  - IDLE: on go, go to PULSE1. Set busy=1 and clear done in the same edge.
  - PULSE1: start_s1=1 for exactly this cycle; counter<=0; go to WAIT1.
  - WAIT1: counter increments each cycle; at counter==S1_CYCLES-1 go to PULSE2.
  - PULSE2: start_s2=1 for exactly this cycle; counter<=0; go to RUN.
  - RUN: counter increments; at counter==RUN_CYCLES-1 go to CAPTURE.
  - CAPTURE: result register <= result_in; go to IDLE; busy<=0; done<=1.
- Latencies:
  - go to start_s1 rising: 1 cycle.
  - start_s1 to start_s2: S1_CYCLES+1 cycles.
  - start_s2 to done rising: RUN_CYCLES+2 cycles.
- start_s1/start_s2 are registered outputs, never both high in the same cycle.
- go while busy is ignored.
- go and abort in the same cycle while IDLE: abort wins, no run starts.
- Abort in any non-IDLE state:
  - Next state IDLE, busy=0, done unchanged (stays 0), result register unchanged.
  - A start pulse scheduled for that cycle is suppressed.
- Counter does not wrap in legal configurations; out-of-range parameter values are a configuration error, not handled.

Decomposition:
- Shared package amer_put_pkg holds:
  - address constants ADDR_P_UP_LO … ADDR_STATUS;
  - the state enum (IDLE, PULSE1, WAIT1, PULSE2, RUN, CAPTURE);
  - default S1_CYCLES/RUN_CYCLES for n=4000.
- One natural sub-module: amer_put_param_regs (write decode, five 64-bit registers, busy write-lock, read mux with result/status).
- FSM and counter stay in the top of this block.

Test Plan:
- Reset then read addresses 0-12 -> all rd_data=0; busy=0, done=0, start pulses never asserted.
- Write 0x3FE00000 to addr 1 and 0x00000001 to addr 0 -> p_up=64'h3FE00000_00000001; readback of addr 0/1 matches one cycle after rd_addr.
- S1_CYCLES=4, RUN_CYCLES=10:
  - go at cycle 0 -> start_s1 high only at cycle 1; start_s2 high only at cycle 6.
  - With result_in=64'h4004_0000_0000_0000, done rises at cycle 18.
  - Addr 10/11 read 0x00000000/0x40040000; status reads 0x2.
- During busy, write addr 2 and pulse go again -> p_down unchanged, no second start_s1, timing identical to the previous test.
- Abort in RUN (cycle 9 of previous timing) -> busy=0 next cycle, done stays 0, no capture; a subsequent go runs a full sequence normally.
- nrst low for one cycle during WAIT1 -> all outputs/parameters 0 next cycle; no start_s2 emitted; a fresh go restarts from PULSE1.
